// File: rtl/alimentador_byte_pkg.sv
// Shared types and framing constants for the byte feeder that sits in front of the modulator.
package alimentador_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    SYNC = 2'd2,
    DATA = 2'd3
  } state_t;

  localparam logic [7:0] DEF_PREAMBLE_BYTE = 8'hAA;
  localparam logic [7:0] DEF_SYNC_BYTE     = 8'h7E;
  localparam logic [7:0] DEF_IDLE_BYTE     = 8'h00;

endpackage

// File: rtl/alimentador_byte_if.sv
// Producer-side byte handshake plus a read-only view of the framing state.
// Handshake: a byte moves when in_valid && in_ready on a rising clk edge; in_ready depends only on the
// buffer fill level, never on in_valid, and in_data must be held stable while in_valid is high.
interface alimentador_byte_if;
  import alimentador_pkg::*;

  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  state_t     dbg_state;

  modport master (output in_data, output in_valid, input in_ready, input dbg_state);
  modport slave  (input in_data, input in_valid, output in_ready, output dbg_state);

endinterface

// File: rtl/alimentador_byte_fifo.sv
// Byte FIFO with power-of-two depth; pointers wrap naturally, push and pop are ignored when full/empty.
module fifo_bytes #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign push_ok = push && (count_q != CW'(DEPTH));
  assign pop_ok  = pop && (count_q != '0);
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
    else if (pop_ok && !push_ok) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: only slots between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/alimentador_byte.sv
// Feeds framed bytes (preamble, sync, payload) to a modulator, advancing one byte a fixed delay after
// each level change on flag_byte.
module alimentador_byte
  import alimentador_pkg::*;
#(
  parameter int         DEPTH         = 8,
  parameter int         PREAMBLE_LEN  = 2,
  parameter int         SWITCH_DELAY  = 32,
  parameter logic [7:0] PREAMBLE_BYTE = DEF_PREAMBLE_BYTE,
  parameter logic [7:0] SYNC_BYTE     = DEF_SYNC_BYTE,
  parameter logic [7:0] IDLE_BYTE     = DEF_IDLE_BYTE
) (
  input  logic                   clk,
  input  logic                   rst,
  alimentador_byte_if.slave      bus,
  input  logic                   flag_byte,
  output logic [7:0]             DADO,
  output logic                   tx_active,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int         CW = $clog2(DEPTH) + 1;
  localparam logic [3:0] PL = 4'(PREAMBLE_LEN);

  logic       flag_prev_q, flag_prev_d;
  logic [7:0] dly_q, dly_d;
  logic       run_q, run_d;
  logic       toggle, adv;

  state_t     state_q, state_d;
  logic [7:0] dado_q, dado_d;
  logic       tx_active_q, tx_active_d;
  logic [3:0] pre_cnt_q, pre_cnt_d;

  logic       push, pop;
  logic [7:0] head;

  assign toggle = (flag_byte != flag_prev_q);
  // A toggle landing on the advance cycle supersedes the pending one.
  assign adv    = run_q && (dly_q == 8'd0) && !toggle;

  assign bus.in_ready  = (fifo_count < CW'(DEPTH));
  assign bus.dbg_state = state_q;
  assign push          = bus.in_valid && bus.in_ready;

  assign DADO      = dado_q;
  assign tx_active = tx_active_q;

  fifo_bytes #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (bus.in_data),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count)
  );

  // Loading DELAY-1 puts the advance exactly SWITCH_DELAY cycles after the toggle cycle.
  always_comb begin
    flag_prev_d = flag_byte;
    dly_d       = dly_q;
    run_d       = run_q;
    if (toggle) begin
      dly_d = 8'(SWITCH_DELAY - 1);
      run_d = 1'b1;
    end else if (run_q) begin
      if (dly_q == 8'd0) run_d = 1'b0;
      else               dly_d = dly_q - 8'd1;
    end
  end

  always_comb begin
    state_d   = state_q;
    dado_d    = dado_q;
    pre_cnt_d = pre_cnt_q;
    pop       = 1'b0;
    if (adv) begin
      case (state_q)
        IDLE: begin
          if (fifo_count != '0) begin
            state_d   = PRE;
            dado_d    = PREAMBLE_BYTE;
            pre_cnt_d = 4'd1;
          end
        end
        PRE: begin
          if (pre_cnt_q < PL) begin
            dado_d    = PREAMBLE_BYTE;
            pre_cnt_d = pre_cnt_q + 4'd1;
          end else begin
            state_d = SYNC;
            dado_d  = SYNC_BYTE;
          end
        end
        SYNC: begin
          state_d = DATA;
          dado_d  = head;
          pop     = 1'b1;
        end
        DATA: begin
          if (fifo_count != '0) begin
            dado_d = head;
            pop    = 1'b1;
          end else begin
            state_d = IDLE;
            dado_d  = IDLE_BYTE;
          end
        end
        default: begin
          state_d = IDLE;
          dado_d  = IDLE_BYTE;
        end
      endcase
    end
    tx_active_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    flag_prev_q <= flag_prev_d;
    if (rst) begin
      dly_q       <= 8'd0;
      run_q       <= 1'b0;
      state_q     <= IDLE;
      dado_q      <= IDLE_BYTE;
      tx_active_q <= 1'b0;
      pre_cnt_q   <= 4'd0;
    end else begin
      dly_q       <= dly_d;
      run_q       <= run_d;
      state_q     <= state_d;
      dado_q      <= dado_d;
      tx_active_q <= tx_active_d;
      pre_cnt_q   <= pre_cnt_d;
    end
  end

endmodule

// File: tb/tb_alimentador_byte.sv
// Bench for alimentador_byte: a frame-list reference model predicts every cycle's outputs into a queue,
// and a negedge monitor pops and compares them.
module tb_alimentador_byte;
  import alimentador_pkg::*;

  localparam int DEPTH = 8;
  localparam int PL    = 2;
  localparam int SD    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int EW    = 32 + 8 + 1 + CW + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flag_byte = 1'b1;
  logic [7:0]    DADO;
  logic          tx_active;
  logic [CW-1:0] fifo_count;

  alimentador_byte_if bus ();

  alimentador_byte #(
    .DEPTH(DEPTH), .PREAMBLE_LEN(PL), .SWITCH_DELAY(SD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .flag_byte  (flag_byte),
    .DADO       (DADO),
    .tx_active  (tx_active),
    .fifo_count (fifo_count)
  );

  // Clock/reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: {cycle, DADO, tx_active, fifo_count, in_ready}
  logic [EW-1:0] exp_q [$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, want);
    end
  endtask

  // Reference model: payload queue, pending framing bytes, frame-open flag
  logic [7:0] fifo_m [$];
  logic [7:0] tx_m [$];
  bit         in_frame = 0;
  logic [7:0] dado_m = DEF_IDLE_BYTE;
  int         adv_at = -1;
  logic       prev_flag = 1'b1;
  logic       flag_cur = 1'b1;

  task automatic frame_advance();
    if (tx_m.size() > 0) begin
      dado_m = tx_m.pop_front();
    end else if (in_frame) begin
      if (fifo_m.size() > 0) dado_m = fifo_m.pop_front();
      else begin
        in_frame = 0;
        dado_m   = DEF_IDLE_BYTE;
      end
    end else if (fifo_m.size() > 0) begin
      in_frame = 1;
      dado_m   = DEF_PREAMBLE_BYTE;
      for (int i = 1; i < PL; i++) tx_m.push_back(DEF_PREAMBLE_BYTE);
      tx_m.push_back(DEF_SYNC_BYTE);
    end
  endtask

  // Driver: one cycle of stimulus, then the model's prediction for the next cycle
  task automatic step(input logic r, input logic f, input logic v, input logic [7:0] d);
    bit            tog, adv, acc, rdy;
    logic [EW-1:0] e;
    @(posedge clk);
    #1;
    rst          = r;
    flag_byte    = f;
    bus.in_valid = v;
    bus.in_data  = d;
    if (r) begin
      fifo_m.delete();
      tx_m.delete();
      in_frame = 0;
      dado_m   = DEF_IDLE_BYTE;
      adv_at   = -1;
    end else begin
      tog = (f !== prev_flag);
      adv = (adv_at == cyc) && !tog;
      if (tog)      adv_at = cyc + SD;
      else if (adv) adv_at = -1;
      acc = v && (fifo_m.size() < DEPTH);
      if (adv) frame_advance();
      if (acc) fifo_m.push_back(d);
    end
    prev_flag = f;
    rdy = (fifo_m.size() < DEPTH);
    e = {32'(cyc + 1), dado_m, in_frame, CW'(fifo_m.size()), rdy};
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, flag_cur, 1'b0, 8'h00);
  endtask

  task automatic tog();
    flag_cur = ~flag_cur;
    step(1'b0, flag_cur, 1'b0, 8'h00);
  endtask

  task automatic push_byte(input logic [7:0] d);
    step(1'b0, flag_cur, 1'b1, d);
  endtask

  // Monitor
  logic [EW-1:0] hd;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      hd = exp_q[0];
      if (int'(hd[EW-1 -: 32]) == cyc) begin
        void'(exp_q.pop_front());
        chk("dado",       32'(DADO),         32'(hd[CW+9 -: 8]));
        chk("tx_active",  32'(tx_active),    32'(hd[CW+1]));
        chk("fifo_count", 32'(fifo_count),   32'(hd[CW:1]));
        chk("in_ready",   32'(bus.in_ready), 32'(hd[0]));
      end
    end
  end

  initial begin
    int gap;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    // Reset with flag high, then no advance while flag stays high
    repeat (3) step(1'b1, 1'b1, 1'b0, 8'h00);
    idle(60);

    // Two-byte frame, one toggle every 256 cycles
    push_byte(8'h3C);
    push_byte(8'h81);
    repeat (8) begin
      tog();
      idle(255);
    end

    // Advance timing and restart on a superseding toggle
    push_byte(8'h5A);
    tog();
    idle(49);
    tog();
    idle(9);
    tog();
    idle(59);
    repeat (5) begin
      tog();
      idle(39);
    end

    // Fill past capacity, then drain as one frame
    for (int i = 0; i < 9; i++) push_byte(8'($urandom_range(0, 255)));
    idle(5);
    repeat (13) begin
      tog();
      idle(39);
    end

    // One push per advance, pushed on the advance cycle itself
    for (int i = 0; i < 3; i++) push_byte(8'($urandom_range(0, 255)));
    repeat (12) begin
      tog();
      idle(31);
      push_byte(8'($urandom_range(0, 255)));
      idle(7);
    end
    repeat (8) begin
      tog();
      idle(39);
    end

    // Reset during payload with bytes still queued, then a fresh frame
    for (int i = 0; i < 5; i++) push_byte(8'($urandom_range(0, 255)));
    repeat (5) begin
      tog();
      idle(39);
    end
    step(1'b1, flag_cur, 1'b0, 8'h00);
    idle(3);
    push_byte(8'hC7);
    repeat (6) begin
      tog();
      idle(39);
    end

    // Random traffic with random toggle gaps (never exactly the delay)
    gap = 10;
    for (int i = 0; i < 2000; i++) begin
      if (gap == 0) begin
        flag_cur = ~flag_cur;
        gap = ($urandom_range(0, 1) == 0) ? int'($urandom_range(3, 25)) : int'($urandom_range(34, 60));
      end else begin
        gap--;
      end
      step(1'b0, flag_cur, ($urandom_range(0, 99) < 30), 8'($urandom_range(0, 255)));
    end
    idle(3);

    repeat (2) @(posedge clk);
    chk("drain", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
